ulpb_iso_seq: RTL and testbench

- Parametrised, always-on power/isolation sequencer for NUM_DOM independently power-gated layer-controller domains.
- Each domain gets an ordered wake sequence (power, clock, reset, isolation release) and an ordered sleep sequence (isolation, reset, clock, power), with programmable per-step dwell counts.
- Sleep is held off until in-flight bus traffic drains.
- Sits between the bus controller and the gated layer controllers. Per-domain BC->LC and LC->BC vectors are clamped to 0 whenever the domain is isolated.

---
 rtl/ulpb_iso_seq.sv | 240 ++++++++++++++++++++++++
 tb/tb_ulpb_iso_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ulpb_iso_seq.sv
// ulpb_iso_seq: always-on power/isolation sequencer for NUM_DOM power-gated
// layer-controller domains. Each domain runs its own FSM:
//   wake : power -> clock -> reset release -> isolation release
//   sleep: (drain) -> isolation -> reset -> clock -> power
// Bus vectors crossing a domain boundary are clamped to 0 while isolated.
// Optional feature macro: ULPB_ISO_SEQ_TIMEOUT_EN (bounded drain wait that
// forces isolation after TIMEOUT_CYC busy cycles).
module ulpb_iso_seq #(
    parameter int NUM_DOM     = 2,
    parameter int IN_W        = 8,
    parameter int OUT_W       = 8,
    parameter int DLY_W       = 4,
    parameter int PWR_DLY     = 4,
    parameter int CLK_DLY     = 2,
    parameter int RST_DLY     = 2,
    parameter int TIMEOUT_CYC = 64,
    parameter int TO_W        = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [NUM_DOM-1:0]       WAKE_REQ,
    input  logic [NUM_DOM-1:0]       SLEEP_REQ,
    input  logic [NUM_DOM-1:0]       BUSY,
    output logic [NUM_DOM-1:0]       WAKE_ACK,
    output logic [NUM_DOM-1:0]       SLEEP_ACK,
    output logic [NUM_DOM-1:0]       POWER_ON,
    output logic [NUM_DOM-1:0]       RELEASE_CLK,
    output logic [NUM_DOM-1:0]       RELEASE_RST,
    output logic [NUM_DOM-1:0]       RELEASE_ISO,
    output logic [NUM_DOM-1:0]       DRAIN_TIMEOUT,
    input  logic [NUM_DOM*IN_W-1:0]  DATA_FROM_BC,
    output logic [NUM_DOM*IN_W-1:0]  DATA_TO_LC,
    input  logic [NUM_DOM*OUT_W-1:0] DATA_FROM_LC,
    output logic [NUM_DOM*OUT_W-1:0] DATA_TO_BC
);

    // A dwell of 0 behaves like a dwell of 1 (a step always lasts one edge).
    localparam int PWR_EFF = (PWR_DLY == 0) ? 1 : PWR_DLY;
    localparam int CLK_EFF = (CLK_DLY == 0) ? 1 : CLK_DLY;
    localparam int RST_EFF = (RST_DLY == 0) ? 1 : RST_DLY;
    localparam int DLY_MAX = (2 ** DLY_W) - 1;

    localparam logic [DLY_W-1:0] PWR_LD   = DLY_W'(PWR_EFF - 1);
    localparam logic [DLY_W-1:0] CLK_LD   = DLY_W'(CLK_EFF - 1);
    localparam logic [DLY_W-1:0] RST_LD   = DLY_W'(RST_EFF - 1);
    localparam logic [DLY_W-1:0] CNT_ONE  = DLY_W'(1);
    localparam logic [DLY_W-1:0] CNT_ZERO = DLY_W'(0);

    // Reject dwell values the counter cannot hold.
    if ((PWR_DLY > DLY_MAX) || (CLK_DLY > DLY_MAX) || (RST_DLY > DLY_MAX)) begin : g_bad_dly
        $error("ulpb_iso_seq: a dwell parameter exceeds the DLY_W counter range");
    end

    // The drain timeout must be representable in the TO_W counter.
    if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC > (2 ** TO_W))) begin : g_bad_to
        $error("ulpb_iso_seq: TIMEOUT_CYC does not fit the TO_W counter");
    end

    typedef enum logic [3:0] {
        ST_OFF    = 4'd0,
        ST_PWR_UP = 4'd1,
        ST_CLK_UP = 4'd2,
        ST_RST_UP = 4'd3,
        ST_ON     = 4'd4,
        ST_DRAIN  = 4'd5,
        ST_ISO_DN = 4'd6,
        ST_RST_DN = 4'd7,
        ST_CLK_DN = 4'd8
    } state_t;

    for (genvar d = 0; d < NUM_DOM; d++) begin : g_dom
        state_t           state_q, state_d;
        logic [DLY_W-1:0] cnt_q, cnt_d;
        // chain bits: [0] power, [1] clock, [2] reset release, [3] iso release
        logic [3:0]       chain_q, chain_d;
        logic             wake_ack_q, wake_ack_d;
        logic             sleep_ack_q, sleep_ack_d;
`ifdef ULPB_ISO_SEQ_TIMEOUT_EN
        localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
        localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
        logic [TO_W-1:0]  to_q, to_d;
        logic             to_pulse_q, to_pulse_d;
`endif

        // Next-state, dwell counter and registered-output decode for this domain.
        always_comb begin
            state_d     = state_q;
            cnt_d       = cnt_q;
            wake_ack_d  = 1'b0;
            sleep_ack_d = 1'b0;
`ifdef ULPB_ISO_SEQ_TIMEOUT_EN
            to_d        = to_q;
            to_pulse_d  = 1'b0;
`endif
            case (state_q)
                ST_OFF: begin
                    if (WAKE_REQ[d]) begin
                        state_d = ST_PWR_UP;
                        cnt_d   = PWR_LD;
                    end else begin
                        state_d = ST_OFF;
                    end
                end
                ST_PWR_UP: begin
                    if (cnt_q == CNT_ZERO) begin
                        state_d = ST_CLK_UP;
                        cnt_d   = CLK_LD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_CLK_UP: begin
                    if (cnt_q == CNT_ZERO) begin
                        state_d = ST_RST_UP;
                        cnt_d   = RST_LD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_RST_UP: begin
                    if (cnt_q == CNT_ZERO) begin
                        state_d    = ST_ON;
                        wake_ack_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_ON: begin
                    if (SLEEP_REQ[d]) begin
                        state_d = ST_DRAIN;
`ifdef ULPB_ISO_SEQ_TIMEOUT_EN
                        to_d    = {TO_W{1'b0}};
`endif
                    end else begin
                        state_d = ST_ON;
                    end
                end
                ST_DRAIN: begin
                    // BUSY sampled at the ON->DRAIN edge is ignored, so DRAIN
                    // always lasts at least one cycle.
                    if (!BUSY[d]) begin
                        state_d = ST_ISO_DN;
`ifdef ULPB_ISO_SEQ_TIMEOUT_EN
                    end else if (to_q == TO_LAST) begin
                        state_d    = ST_ISO_DN;
                        to_pulse_d = 1'b1;
                    end else begin
                        to_d = to_q + TO_ONE;
                    end
`else
                    end else begin
                        state_d = ST_DRAIN;
                    end
`endif
                end
                ST_ISO_DN: begin
                    state_d = ST_RST_DN;
                    cnt_d   = RST_LD;
                end
                ST_RST_DN: begin
                    if (cnt_q == CNT_ZERO) begin
                        state_d = ST_CLK_DN;
                        cnt_d   = CLK_LD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_CLK_DN: begin
                    if (cnt_q == CNT_ZERO) begin
                        state_d     = ST_OFF;
                        sleep_ack_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = CNT_ZERO;
                end
            endcase

            // Outputs follow the state being entered, so each step only ever
            // extends or shortens the power->clock->reset->iso chain in order.
            case (state_d)
                ST_OFF:    chain_d = 4'b0000;
                ST_PWR_UP: chain_d = 4'b0001;
                ST_CLK_UP: chain_d = 4'b0011;
                ST_RST_UP: chain_d = 4'b0111;
                ST_ON:     chain_d = 4'b1111;
                ST_DRAIN:  chain_d = 4'b1111;
                ST_ISO_DN: chain_d = 4'b0111;
                ST_RST_DN: chain_d = 4'b0011;
                ST_CLK_DN: chain_d = 4'b0001;
                default:   chain_d = 4'b0000;
            endcase
        end

        // State, counters and registered outputs; reset leaves the domain OFF and isolated.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                state_q     <= ST_OFF;
                cnt_q       <= CNT_ZERO;
                chain_q     <= 4'b0000;
                wake_ack_q  <= 1'b0;
                sleep_ack_q <= 1'b0;
`ifdef ULPB_ISO_SEQ_TIMEOUT_EN
                to_q        <= {TO_W{1'b0}};
                to_pulse_q  <= 1'b0;
`endif
            end else begin
                state_q     <= state_d;
                cnt_q       <= cnt_d;
                chain_q     <= chain_d;
                wake_ack_q  <= wake_ack_d;
                sleep_ack_q <= sleep_ack_d;
`ifdef ULPB_ISO_SEQ_TIMEOUT_EN
                to_q        <= to_d;
                to_pulse_q  <= to_pulse_d;
`endif
            end
        end

        assign POWER_ON[d]    = chain_q[0];
        assign RELEASE_CLK[d] = chain_q[1];
        assign RELEASE_RST[d] = chain_q[2];
        assign RELEASE_ISO[d] = chain_q[3];
        assign WAKE_ACK[d]    = wake_ack_q;
        assign SLEEP_ACK[d]   = sleep_ack_q;
`ifdef ULPB_ISO_SEQ_TIMEOUT_EN
        assign DRAIN_TIMEOUT[d] = to_pulse_q;
`else
        assign DRAIN_TIMEOUT[d] = 1'b0;
`endif

        // Clamp selects come straight from a flop, so the gating is glitch-free.
        assign DATA_TO_LC[d*IN_W +: IN_W]   = chain_q[3] ? DATA_FROM_BC[d*IN_W +: IN_W]   : {IN_W{1'b0}};
        assign DATA_TO_BC[d*OUT_W +: OUT_W] = chain_q[3] ? DATA_FROM_LC[d*OUT_W +: OUT_W] : {OUT_W{1'b0}};
    end

endmodule

// File: tb/tb_ulpb_iso_seq.sv
// Self-checking bench for ulpb_iso_seq. The reference model tracks each
// domain as a phase plus "edges since the phase began" and derives the
// expected outputs from the dwell arithmetic of the wake/sleep timelines.
module tb_ulpb_iso_seq;
    localparam int ND  = 2;
    localparam int IW  = 8;
    localparam int OW  = 8;
    localparam int PD  = 4;
    localparam int CD  = 2;
    localparam int RD  = 2;
    localparam int TOC = 64;
    localparam int PE  = (PD == 0) ? 1 : PD;
    localparam int CE  = (CD == 0) ? 1 : CD;
    localparam int RE  = (RD == 0) ? 1 : RD;
    localparam int WAKE_LEN  = PE + CE + RE;   // edges from wake sample to ON
    localparam int SLEEP_LEN = 1 + RE + CE;    // edges from iso drop to OFF

    localparam int M_OFF = 0, M_WAKE = 1, M_ON = 2, M_DRAIN = 3, M_SLEEP = 4;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic [ND-1:0] wake = '0, slp = '0, busy = '0;
    logic [ND*IW-1:0] from_bc = '0;
    logic [ND*OW-1:0] from_lc = '0;
    logic [ND-1:0] wake_ack, sleep_ack, power_on, rel_clk, rel_rst, rel_iso, drain_to;
    logic [ND*IW-1:0] to_lc;
    logic [ND*OW-1:0] to_bc;

    ulpb_iso_seq #(
        .NUM_DOM(ND), .IN_W(IW), .OUT_W(OW), .DLY_W(4),
        .PWR_DLY(PD), .CLK_DLY(CD), .RST_DLY(RD),
        .TIMEOUT_CYC(TOC), .TO_W(8)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .WAKE_REQ(wake), .SLEEP_REQ(slp), .BUSY(busy),
        .WAKE_ACK(wake_ack), .SLEEP_ACK(sleep_ack),
        .POWER_ON(power_on), .RELEASE_CLK(rel_clk),
        .RELEASE_RST(rel_rst), .RELEASE_ISO(rel_iso),
        .DRAIN_TIMEOUT(drain_to),
        .DATA_FROM_BC(from_bc), .DATA_TO_LC(to_lc),
        .DATA_FROM_LC(from_lc), .DATA_TO_BC(to_bc)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    string phase = "init";

    int mode [ND];
    int tt   [ND];
    int tcnt [ND];
    logic [ND-1:0] e_wack = '0, e_sack = '0, e_to = '0;

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            mode[d] = M_OFF;
            tt[d]   = 0;
            tcnt[d] = 0;
        end
        e_wack = '0;
        e_sack = '0;
        e_to   = '0;
    endtask

    // Advance the model by one clock edge using the inputs held across it.
    task automatic model_edge();
        if (RESET) begin
            model_reset();
        end else begin
            e_wack = '0;
            e_sack = '0;
            e_to   = '0;
            for (int d = 0; d < ND; d++) begin
                case (mode[d])
                    M_OFF: if (wake[d]) begin mode[d] = M_WAKE; tt[d] = 0; end
                    M_WAKE: begin
                        tt[d]++;
                        if (tt[d] == WAKE_LEN) begin mode[d] = M_ON; e_wack[d] = 1'b1; end
                    end
                    M_ON: if (slp[d]) begin mode[d] = M_DRAIN; tcnt[d] = 0; end
                    M_DRAIN: begin
                        if (!busy[d]) begin
                            mode[d] = M_SLEEP; tt[d] = 0;
`ifdef ULPB_ISO_SEQ_TIMEOUT_EN
                        end else if (tcnt[d] == TOC - 1) begin
                            mode[d] = M_SLEEP; tt[d] = 0; e_to[d] = 1'b1;
                        end else begin
                            tcnt[d]++;
`endif
                        end
                    end
                    M_SLEEP: begin
                        tt[d]++;
                        if (tt[d] == SLEEP_LEN) begin mode[d] = M_OFF; e_sack[d] = 1'b1; end
                    end
                    default: mode[d] = M_OFF;
                endcase
            end
        end
    endtask

    // Expected {iso, rst, clk, pwr} from phase and elapsed edges.
    function automatic logic [3:0] exp_chain(input int d);
        logic [3:0] c;
        c = 4'b0000;
        case (mode[d])
            M_WAKE:  c = {1'b0, (tt[d] >= PE + CE), (tt[d] >= PE), 1'b1};
            M_ON:    c = 4'b1111;
            M_DRAIN: c = 4'b1111;
            M_SLEEP: c = {1'b0, (tt[d] < 1), (tt[d] < 1 + RE), 1'b1};
            default: c = 4'b0000;
        endcase
        return c;
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s %s[%0d] observed=%0h expected=%0h at %0t", phase, tag, d, obs, expv, $time);
        end
    endtask

    task automatic check_all();
        logic [3:0] c;
        logic [IW-1:0] elc;
        logic [OW-1:0] ebc;
        for (int d = 0; d < ND; d++) begin
            c   = exp_chain(d);
            elc = c[3] ? from_bc[d*IW +: IW] : '0;
            ebc = c[3] ? from_lc[d*OW +: OW] : '0;
            chk("power_on",      d, 32'(power_on[d]),  32'(c[0]));
            chk("release_clk",   d, 32'(rel_clk[d]),   32'(c[1]));
            chk("release_rst",   d, 32'(rel_rst[d]),   32'(c[2]));
            chk("release_iso",   d, 32'(rel_iso[d]),   32'(c[3]));
            chk("wake_ack",      d, 32'(wake_ack[d]),  32'(e_wack[d]));
            chk("sleep_ack",     d, 32'(sleep_ack[d]), 32'(e_sack[d]));
            chk("drain_timeout", d, 32'(drain_to[d]),  32'(e_to[d]));
            chk("data_to_lc",    d, 32'(to_lc[d*IW +: IW]), 32'(elc));
            chk("data_to_bc",    d, 32'(to_bc[d*OW +: OW]), 32'(ebc));
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        model_reset();

        phase = "reset";
        from_bc = {8'h5A, 8'hA5};
        from_lc = {8'hC3, 8'h3C};
        run(3);

        phase = "idle";
        RESET = 1'b0;
        run(3);

        // Wake domain 0; WAKE_REQ left high into ON must have no effect.
        phase = "wake0";
        wake = 2'b01;
        run(WAKE_LEN + 4);

        // Sleep with no traffic in flight.
        phase = "sleep0";
        wake = 2'b00;
        slp  = 2'b01;
        step();
        slp  = 2'b00;
        run(SLEEP_LEN + 3);

        // Drain held off by BUSY for 20 cycles.
        phase = "busy_drain";
        wake = 2'b01;
        step();
        wake = 2'b00;
        run(WAKE_LEN + 1);
        slp  = 2'b01;
        busy = 2'b01;
        step();
        slp  = 2'b00;
        run(19);
        busy = 2'b00;
        run(SLEEP_LEN + 3);

        // WAKE_REQ held through a sleep: completes to OFF, then rewakes.
        phase = "wake_held";
        wake = 2'b01;
        run(WAKE_LEN + 1);
        slp  = 2'b01;
        step();
        slp  = 2'b00;
        run(SLEEP_LEN + WAKE_LEN + 4);
        wake = 2'b00;
        slp  = 2'b01;
        step();
        slp  = 2'b00;
        run(SLEEP_LEN + 3);

        // Asynchronous reset in the middle of the reset-release dwell.
        phase = "reset_mid";
        wake = 2'b01;
        step();
        wake = 2'b00;
        run(PE + CE);
        RESET = 1'b1;
        #2;
        model_reset();
        check_all();
        run(2);
        RESET = 1'b0;
        run(6);

        // Random traffic on both domains.
        phase = "random";
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < ND; d++) begin
                wake[d] = ($urandom_range(0, 9) < 3);
                slp[d]  = ($urandom_range(0, 9) < 3);
                busy[d] = ($urandom_range(0, 9) < 5);
            end
            from_bc = ND*IW'($urandom);
            from_lc = ND*OW'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
